// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the Zicsr access sequencer: funct3 encodings,
// FSM states and the read-only CSR address space marker.
package csr_access_unit_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  // addr[11:10] == 2'b11 marks the read-only CSR space
  localparam logic [1:0] RO_ADDR_TOP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // funct3 000 and 100 are not Zicsr ops
  function automatic logic f3_reserved(input logic [2:0] f3);
    return (f3[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/csr_wdata_gen.sv
// Combinational write-decision for one Zicsr op: whether to write, the new
// value, and whether the write would hit the read-only CSR space.
module csr_wdata_gen
  import csr_access_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_addr,
  input  logic [31:0] i_old,
  input  logic [31:0] i_src,
  input  logic        i_is_x0,
  output logic        o_wr,
  output logic [31:0] o_new,
  output logic        o_ro_violation
);

  always_comb begin
    o_wr  = 1'b0;
    o_new = i_old;
    case (i_funct3)
      F3_RW, F3_RWI: begin
        o_wr  = 1'b1;
        o_new = i_src;
      end
      // set/clear with a zero operand is a pure read and must not write
      F3_RS, F3_RSI: begin
        o_wr  = !i_is_x0;
        o_new = i_old | i_src;
      end
      F3_RC, F3_RCI: begin
        o_wr  = !i_is_x0;
        o_new = i_old & ~i_src;
      end
      default: begin
        o_wr  = 1'b0;
        o_new = i_old;
      end
    endcase
    o_ro_violation = o_wr && (i_addr[11:10] == RO_ADDR_TOP);
  end

endmodule

// File: rtl/csr_access_unit.sv
// Execute-stage Zicsr sequencer: read old CSR value, decide/issue the write,
// and return the old value (or an illegal-instruction flag) for rd.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        I_VALID,
  output logic        I_READY,
  input  logic [2:0]  I_FUNCT3,
  input  logic [11:0] I_ADDR,
  input  logic [31:0] I_SRC,
  input  logic        I_SRC_IS_X0,
  input  logic [4:0]  I_RD,
  output logic        CSR_RDEN,
  output logic [11:0] CSR_RADDR,
  input  logic        CSR_RVALID,
  input  logic [31:0] CSR_RDATA,
  output logic        CSR_WREN,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic [4:0]  O_RD,
  output logic [31:0] O_DATA,
  output logic        O_ILLEGAL,
  output state_t      o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the valid side holds its payload stable until that edge.

  localparam logic [3:0] TO_LAST = 4'(RD_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_funct3;
  logic [11:0] r_addr;
  logic [31:0] r_src;
  logic        r_is_x0;
  logic [4:0]  r_rd;
  logic [31:0] r_old;
  logic [31:0] r_new;
  logic        r_illegal;
  logic [3:0]  r_cnt;

  logic        w_wr;
  logic [31:0] w_new;
  logic        w_ro;
  logic        w_rsvd;
  logic        w_accept;

  csr_wdata_gen u_wdata_gen (
    .i_funct3       (r_funct3),
    .i_addr         (r_addr),
    .i_old          (CSR_RDATA),
    .i_src          (r_src),
    .i_is_x0        (r_is_x0),
    .o_wr           (w_wr),
    .o_new          (w_new),
    .o_ro_violation (w_ro)
  );

  assign w_rsvd      = f3_reserved(r_funct3);
  assign w_accept    = (r_state == ST_IDLE) && I_VALID && !FLUSH;
  assign o_dbg_state = r_state;

  always_comb begin
    w_next    = r_state;
    I_READY   = 1'b0;
    CSR_RDEN  = 1'b0;
    CSR_RADDR = '0;
    CSR_WREN  = 1'b0;
    CSR_WADDR = '0;
    CSR_WDATA = '0;
    O_VALID   = 1'b0;
    O_ILLEGAL = 1'b0;
    O_RD      = '0;
    O_DATA    = '0;
    case (r_state)
      ST_IDLE: begin
        I_READY = 1'b1;
        if (w_accept) w_next = ST_READ;
      end
      ST_READ: begin
        if (FLUSH) begin
          w_next = ST_IDLE;
        end else if (w_rsvd) begin
          w_next = ST_RESP;
        end else begin
          w_next    = ST_WAIT;
          CSR_RDEN  = 1'b1;
          CSR_RADDR = r_addr;
        end
      end
      ST_WAIT: begin
        if (FLUSH) begin
          w_next = ST_IDLE;
        end else if (CSR_RVALID) begin
          w_next = (w_wr && !w_ro) ? ST_WRITE : ST_RESP;
        end else if (r_cnt == TO_LAST) begin
          w_next = ST_RESP;
        end
      end
      ST_WRITE: begin
        // the write commits even under FLUSH; only the response is dropped
        CSR_WREN  = 1'b1;
        CSR_WADDR = r_addr;
        CSR_WDATA = r_new;
        w_next    = FLUSH ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        O_VALID   = 1'b1;
        O_ILLEGAL = r_illegal;
        O_RD      = r_illegal ? 5'd0 : r_rd;
        O_DATA    = r_illegal ? 32'd0 : r_old;
        if (FLUSH || O_READY) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_funct3  <= '0;
      r_addr    <= '0;
      r_src     <= '0;
      r_is_x0   <= 1'b0;
      r_rd      <= '0;
      r_old     <= '0;
      r_new     <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_funct3  <= I_FUNCT3;
            r_addr    <= I_ADDR;
            r_src     <= I_SRC;
            r_is_x0   <= I_SRC_IS_X0;
            r_rd      <= I_RD;
            r_old     <= '0;
            r_illegal <= 1'b0;
          end
        end
        ST_READ: begin
          r_cnt <= '0;
          if (w_rsvd) r_illegal <= 1'b1;
        end
        ST_WAIT: begin
          if (CSR_RVALID) begin
            r_old     <= CSR_RDATA;
            r_new     <= w_new;
            r_illegal <= w_ro;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            // read window expired without RVALID: flag the op illegal
            if (r_cnt == TO_LAST) r_illegal <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: a csrs responder, a driver task, and a
// monitor that pops expected writes and responses from scoreboard queues.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  logic        CLK;
  logic        RST;
  logic        FLUSH;
  logic        I_VALID;
  logic        I_READY;
  logic [2:0]  I_FUNCT3;
  logic [11:0] I_ADDR;
  logic [31:0] I_SRC;
  logic        I_SRC_IS_X0;
  logic [4:0]  I_RD;
  logic        CSR_RDEN;
  logic [11:0] CSR_RADDR;
  logic        CSR_RVALID;
  logic [31:0] CSR_RDATA;
  logic        CSR_WREN;
  logic [11:0] CSR_WADDR;
  logic [31:0] CSR_WDATA;
  logic        O_VALID;
  logic        O_READY;
  logic [4:0]  O_RD;
  logic [31:0] O_DATA;
  logic        O_ILLEGAL;
  state_t      o_dbg_state;

  csr_access_unit #(.RD_TIMEOUT(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FLUSH       (FLUSH),
    .I_VALID     (I_VALID),
    .I_READY     (I_READY),
    .I_FUNCT3    (I_FUNCT3),
    .I_ADDR      (I_ADDR),
    .I_SRC       (I_SRC),
    .I_SRC_IS_X0 (I_SRC_IS_X0),
    .I_RD        (I_RD),
    .CSR_RDEN    (CSR_RDEN),
    .CSR_RADDR   (CSR_RADDR),
    .CSR_RVALID  (CSR_RVALID),
    .CSR_RDATA   (CSR_RDATA),
    .CSR_WREN    (CSR_WREN),
    .CSR_WADDR   (CSR_WADDR),
    .CSR_WDATA   (CSR_WDATA),
    .O_VALID     (O_VALID),
    .O_READY     (O_READY),
    .O_RD        (O_RD),
    .O_DATA      (O_DATA),
    .O_ILLEGAL   (O_ILLEGAL),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int rden_cnt = 0;
  logic [37:0] exp_q[$];   // {illegal, rd, data}
  logic [43:0] wr_q[$];    // {waddr, wdata}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- csrs responder ----------------
  int          rsp_delay = -1;
  logic [31:0] rsp_data = '0;

  initial begin
    CSR_RVALID = 1'b0;
    CSR_RDATA  = '0;
    forever begin
      @(negedge CLK); #1;
      if (CSR_RDEN && rsp_delay >= 0) begin
        for (int k = 0; k <= rsp_delay; k++) @(negedge CLK);
        CSR_RVALID = 1'b1;
        CSR_RDATA  = rsp_data;
        @(negedge CLK);
        CSR_RVALID = 1'b0;
        CSR_RDATA  = '0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [43:0] w;
    logic [37:0] r;
    forever begin
      @(negedge CLK); #1;
      if (CSR_RDEN) begin
        rden_cnt++;
        check("rden_wren_exclusive", 64'(CSR_WREN), 64'd0);
      end
      if (CSR_WREN) begin
        if (wr_q.size() == 0) check("unexpected_write", 64'({CSR_WADDR, CSR_WDATA}), 64'd0 - 64'd1);
        else begin
          w = wr_q.pop_front();
          check("write", 64'({CSR_WADDR, CSR_WDATA}), 64'(w));
        end
      end
      if (O_VALID && O_READY) begin
        if (exp_q.size() == 0) check("unexpected_resp", 64'({O_ILLEGAL, O_RD, O_DATA}), 64'd0 - 64'd1);
        else begin
          r = exp_q.pop_front();
          check("resp", 64'({O_ILLEGAL, O_RD, O_DATA}), 64'(r));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Starts and ends at a negedge. exp_lat counts rising edges from the issue
  // edge (inclusive) to the edge after which O_VALID is visible.
  task automatic run_op(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] src,
                        input logic x0, input logic [4:0] rd, input int dly, input logic [31:0] rdata,
                        input logic exp_wr, input logic [31:0] exp_wdata, input logic exp_ill,
                        input logic [31:0] exp_old, input int exp_lat, input int hold);
    int lat;
    int guard;
    logic [37:0] e;
    guard = 0;
    while (!I_READY && guard < 50) begin @(negedge CLK); guard++; end
    check("issue_ready", 64'(I_READY), 64'd1);
    rsp_delay = dly;
    rsp_data  = rdata;
    if (exp_wr) wr_q.push_back({addr, exp_wdata});
    e = {exp_ill, exp_ill ? 5'd0 : rd, exp_ill ? 32'd0 : exp_old};
    exp_q.push_back(e);
    O_READY     = (hold == 0);
    I_VALID     = 1'b1;
    I_FUNCT3    = f3;
    I_ADDR      = addr;
    I_SRC       = src;
    I_SRC_IS_X0 = x0;
    I_RD        = rd;
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      I_VALID = 1'b0;
    end while (!O_VALID && lat < 40);
    check("latency", 64'(lat), 64'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      check("hold_valid", 64'(O_VALID), 64'd1);
      check("hold_payload", 64'({O_ILLEGAL, O_RD, O_DATA}), 64'(e));
      check("hold_iready", 64'(I_READY), 64'd0);
      @(negedge CLK);
    end
    O_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("ready_after_resp", 64'(I_READY), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    int guard;
    RST = 1'b0; FLUSH = 1'b0; I_VALID = 1'b0; I_FUNCT3 = '0; I_ADDR = '0;
    I_SRC = '0; I_SRC_IS_X0 = 1'b0; I_RD = '0; O_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
    check("rst_iready", 64'(I_READY), 64'd1);
    check("rst_strobes", 64'({CSR_RDEN, CSR_WREN, O_VALID, O_ILLEGAL}), 64'd0);
    check("rst_outs", 64'({CSR_RADDR, CSR_WADDR, CSR_WDATA}), 64'd0);
    check("rst_resp", 64'({O_RD, O_DATA}), 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    //     f3      addr     src           x0 rd  dly rdata         wr wdata         ill old           lat hold
    run_op(F3_RW,  12'h340, 32'hDEADBEEF, 0, 5,  0,  32'h12345678, 1, 32'hDEADBEEF, 0, 32'h12345678, 4, 0);
    run_op(F3_RS,  12'h300, 32'h8,        0, 6,  0,  32'h1800,     1, 32'h1808,     0, 32'h1800,     4, 0);
    run_op(F3_RC,  12'h300, 32'h8,        0, 7,  0,  32'h1808,     1, 32'h1800,     0, 32'h1808,     4, 0);
    run_op(F3_RS,  12'hF14, 32'h0,        1, 8,  0,  32'h000000A5, 0, 32'h0,        0, 32'h000000A5, 3, 0);
    run_op(F3_RW,  12'hF14, 32'h1,        0, 9,  0,  32'h000000A5, 0, 32'h0,        1, 32'h0,        3, 0);
    run_op(F3_RW,  12'h7FF, 32'h55,       0, 10, -1, 32'h0,        0, 32'h0,        1, 32'h0,        4, 0);
    r0 = rden_cnt;
    run_op(3'b000, 12'h340, 32'h1,        0, 11, 0,  32'h0,        0, 32'h0,        1, 32'h0,        2, 0);
    check("reserved_no_rden", 64'(rden_cnt - r0), 64'd0);
    run_op(F3_RSI, 12'h305, 32'h3,        0, 12, 1,  32'h100,      1, 32'h103,      0, 32'h100,      5, 0);
    run_op(F3_RCI, 12'h305, 32'h1,        0, 13, 0,  32'h103,      1, 32'h102,      0, 32'h103,      4, 5);

    // FLUSH while waiting for read data: no write, no response
    rsp_delay = -1;
    I_VALID = 1'b1; I_FUNCT3 = F3_RW; I_ADDR = 12'h340; I_SRC = 32'h1; I_SRC_IS_X0 = 1'b0; I_RD = 5'd4;
    @(posedge CLK); @(negedge CLK);
    I_VALID = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("flush_wait_state", 64'(o_dbg_state), 64'(ST_WAIT));
    FLUSH = 1'b1;
    @(posedge CLK); @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_wait_idle", 64'({I_READY, o_dbg_state}), 64'({1'b1, ST_IDLE}));
    repeat (6) @(negedge CLK);

    // FLUSH in IDLE masks an offered op
    r0 = rden_cnt;
    I_VALID = 1'b1; FLUSH = 1'b1;
    @(posedge CLK); @(negedge CLK);
    I_VALID = 1'b0; FLUSH = 1'b0;
    check("flush_idle_state", 64'(o_dbg_state), 64'(ST_IDLE));
    @(posedge CLK); @(negedge CLK);
    check("flush_idle_no_rden", 64'(rden_cnt - r0), 64'd0);

    // reset asserted while the write strobe is out
    rsp_delay = 0; rsp_data = 32'h22;
    wr_q.push_back({12'h341, 32'h11});
    I_VALID = 1'b1; I_FUNCT3 = F3_RW; I_ADDR = 12'h341; I_SRC = 32'h11; I_SRC_IS_X0 = 1'b0; I_RD = 5'd3;
    @(posedge CLK); @(negedge CLK);
    I_VALID = 1'b0;
    guard = 0;
    while (!CSR_WREN && guard < 10) begin @(negedge CLK); guard++; end
    check("rst_mid_write_seen", 64'(CSR_WREN), 64'd1);
    RST = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("rst_mid_wren", 64'(CSR_WREN), 64'd0);
    check("rst_mid_iready", 64'(I_READY), 64'd1);
    check("rst_mid_ovalid", 64'(O_VALID), 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    run_op(F3_RW,  12'h340, 32'hCAFEF00D, 0, 1,  0,  32'hDEADBEEF, 1, 32'hCAFEF00D, 0, 32'hDEADBEEF, 4, 0);
    run_op(F3_RCI, 12'h344, 32'h4,        0, 2,  0,  32'h000000FF, 1, 32'h000000FB, 0, 32'h000000FF, 4, 0);

    repeat (4) @(negedge CLK);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
